// File: rtl/stq_cam_partitioned_mp.sv
// Partition-gated, multi-port store-queue CAM.
// Each partition is one stq_cam_part instance. The instance holds the partition's
// tags, valid bits, power FSM and registered search result. The top level only
// fans the shared buses out to the partitions and stitches their results together.

module stq_cam_part #(
    parameter int RPORT     = 2,
    parameter int WPORT     = 2,
    parameter int INDEX     = 5,
    parameter int WIDTH     = 32,
    parameter int PDEPTH    = 8,
    parameter int PARTS_LOG = 2,
    parameter int PART_ID   = 0,
    parameter int FUNCTION  = 0,
    parameter int WAKE_CYC  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     part_active,
    input  logic [WPORT*INDEX-1:0]   wr_addr,
    input  logic [WPORT*WIDTH-1:0]   wr_data,
    input  logic [WPORT-1:0]         we,
    input  logic [INDEX-1:0]         inv_addr,
    input  logic                     inv,
    input  logic                     flush,
    input  logic [RPORT*WIDTH-1:0]   tag,
    input  logic [RPORT-1:0]         tag_valid,
    output logic                     ready,
    output logic [PDEPTH-1:0]        valid,
    output logic [RPORT*PDEPTH-1:0]  vect
);
    localparam int LIDX = INDEX - PARTS_LOG;
    localparam int CW   = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

    typedef enum logic [1:0] {ACTIVE, OFF, WAKE} pstate_t;

    pstate_t              state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 is_act;
    logic [WIDTH-1:0]     tags [PDEPTH];
    logic [PDEPTH-1:0]    wr_en;
    logic [WIDTH-1:0]     wr_dat [PDEPTH];
    logic [PDEPTH-1:0]    inv_hit;
    logic [RPORT*PDEPTH-1:0] hit;

    function automatic logic cmp_f(input logic [WIDTH-1:0] stored,
                                   input logic [WIDTH-1:0] key);
        if (FUNCTION == 1) return stored > key;
        else               return stored == key;
    endfunction

    assign is_act = (state == ACTIVE);
    assign ready  = is_act;

    // Power state and wake counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACTIVE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Power FSM: off on request, fixed-length wake before becoming usable again.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ACTIVE: if (!part_active) state_n = OFF;
            OFF: if (part_active) begin
                state_n = WAKE;
                cnt_n   = CW'(WAKE_CYC - 1);
            end
            WAKE: begin
                if (!part_active)    state_n = OFF;
                else if (cnt == '0)  state_n = ACTIVE;
                else                 cnt_n   = cnt - 1'b1;
            end
            default: state_n = ACTIVE;
        endcase
    end

    // Per-entry write select; later ports override earlier ones so the highest port wins.
    always_comb begin
        wr_en = '0;
        for (int e = 0; e < PDEPTH; e++) begin
            wr_dat[e] = '0;
            for (int w = 0; w < WPORT; w++) begin
                if (we[w] &&
                    wr_addr[w*INDEX + INDEX-1 -: PARTS_LOG] == PARTS_LOG'(PART_ID) &&
                    wr_addr[w*INDEX +: LIDX] == LIDX'(e)) begin
                    wr_en[e]  = 1'b1;
                    wr_dat[e] = wr_data[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Invalidate decode for this partition.
    always_comb begin
        inv_hit = '0;
        for (int e = 0; e < PDEPTH; e++)
            inv_hit[e] = inv &&
                         inv_addr[INDEX-1 -: PARTS_LOG] == PARTS_LOG'(PART_ID) &&
                         inv_addr[LIDX-1:0] == LIDX'(e);
    end

    // Tag storage; not reset, only written while the partition is usable.
    always_ff @(posedge clk) begin
        for (int e = 0; e < PDEPTH; e++)
            if (is_act && wr_en[e]) tags[e] <= wr_dat[e];
    end

    // Valid bits: flush > power-off clear > write > invalidate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else begin
            for (int e = 0; e < PDEPTH; e++) begin
                if (flush)                   valid[e] <= 1'b0;
                else if (state_n == OFF)     valid[e] <= 1'b0;
                else if (is_act && wr_en[e]) valid[e] <= 1'b1;
                else if (inv_hit[e])         valid[e] <= 1'b0;
            end
        end
    end

    // Search against pre-edge contents.
    always_comb begin
        hit = '0;
        for (int r = 0; r < RPORT; r++)
            for (int e = 0; e < PDEPTH; e++)
                hit[r*PDEPTH + e] = tag_valid[r] & valid[e] & is_act &
                                    cmp_f(tags[e], tag[r*WIDTH +: WIDTH]);
    end

    // Registered match vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vect <= '0;
        else       vect <= hit;
    end
endmodule

module stq_cam_partitioned_mp #(
    parameter int RPORT     = 2,
    parameter int WPORT     = 2,
    parameter int DEPTH     = 32,
    parameter int INDEX     = 5,
    parameter int WIDTH     = 32,
    parameter int NUM_PARTS = 4,
    parameter int PARTS_LOG = 2,
    parameter int FUNCTION  = 0,
    parameter int WAKE_CYC  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [RPORT*WIDTH-1:0]    tag_i,
    input  logic [RPORT-1:0]          tagValid_i,
    output logic [RPORT*DEPTH-1:0]    vect_o,
    input  logic [WPORT*INDEX-1:0]    wrAddr_i,
    input  logic [WPORT*WIDTH-1:0]    wrData_i,
    input  logic [WPORT-1:0]          we_i,
    input  logic [INDEX-1:0]          invAddr_i,
    input  logic                      inv_i,
    input  logic                      flush_i,
    input  logic [NUM_PARTS-1:0]      partActive_i,
    output logic [NUM_PARTS-1:0]      partReady_o,
    output logic [DEPTH-1:0]          validVect_o
);
    localparam int PDEPTH = DEPTH / NUM_PARTS;

    logic [NUM_PARTS-1:0][RPORT*PDEPTH-1:0] part_vect;

    for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
        stq_cam_part #(
            .RPORT(RPORT), .WPORT(WPORT), .INDEX(INDEX), .WIDTH(WIDTH),
            .PDEPTH(PDEPTH), .PARTS_LOG(PARTS_LOG), .PART_ID(p),
            .FUNCTION(FUNCTION), .WAKE_CYC(WAKE_CYC)
        ) u_part (
            .clk        (clk),
            .reset      (reset),
            .part_active(partActive_i[p]),
            .wr_addr    (wrAddr_i),
            .wr_data    (wrData_i),
            .we         (we_i),
            .inv_addr   (invAddr_i),
            .inv        (inv_i),
            .flush      (flush_i),
            .tag        (tag_i),
            .tag_valid  (tagValid_i),
            .ready      (partReady_o[p]),
            .valid      (validVect_o[p*PDEPTH +: PDEPTH]),
            .vect       (part_vect[p])
        );
        // Partition-local results land at global entry positions.
        for (genvar r = 0; r < RPORT; r++) begin : g_map
            assign vect_o[r*DEPTH + p*PDEPTH +: PDEPTH] = part_vect[p][r*PDEPTH +: PDEPTH];
        end
    end
endmodule

// File: tb/tb_stq_cam_partitioned_mp.sv
// Bench for stq_cam_partitioned_mp: two instances (equality and greater-than compare)
// share stimulus; a behavioural model predicts every output each cycle.

module tb_stq_cam_partitioned_mp;
    localparam int WAKE = 4;

    logic        clk = 0;
    logic        reset = 1;
    logic [63:0] tag_i = '0;
    logic [1:0]  tagValid_i = '0;
    logic [63:0] vect0, vect1;
    logic [9:0]  wrAddr_i = '0;
    logic [63:0] wrData_i = '0;
    logic [1:0]  we_i = '0;
    logic [4:0]  invAddr_i = '0;
    logic        inv_i = 0;
    logic        flush_i = 0;
    logic [3:0]  partActive_i = 4'hF;
    logic [3:0]  ready0, ready1;
    logic [31:0] valid0, valid1;

    int compared = 0;
    int mismatched = 0;

    // Model: valid/tag per entry; wl[p] = -1 off, 0 usable, >0 cycles left in wake.
    bit          mv [32];
    logic [31:0] mt [32];
    int          wl [4];
    logic [63:0] ev0, ev1;

    always #5 clk = ~clk;

    stq_cam_partitioned_mp #(.FUNCTION(0), .WAKE_CYC(WAKE)) dut_eq (
        .clk(clk), .reset(reset), .tag_i(tag_i), .tagValid_i(tagValid_i),
        .vect_o(vect0), .wrAddr_i(wrAddr_i), .wrData_i(wrData_i), .we_i(we_i),
        .invAddr_i(invAddr_i), .inv_i(inv_i), .flush_i(flush_i),
        .partActive_i(partActive_i), .partReady_o(ready0), .validVect_o(valid0));

    stq_cam_partitioned_mp #(.FUNCTION(1), .WAKE_CYC(WAKE)) dut_gt (
        .clk(clk), .reset(reset), .tag_i(tag_i), .tagValid_i(tagValid_i),
        .vect_o(vect1), .wrAddr_i(wrAddr_i), .wrData_i(wrData_i), .we_i(we_i),
        .invAddr_i(invAddr_i), .inv_i(inv_i), .flush_i(flush_i),
        .partActive_i(partActive_i), .partReady_o(ready1), .validVect_o(valid1));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        for (int p = 0; p < 4; p++) r[p] = (wl[p] == 0);
        return r;
    endfunction

    function automatic logic [31:0] m_valid();
        logic [31:0] v;
        for (int e = 0; e < 32; e++) v[e] = mv[e];
        return v;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < 32; e++) mv[e] = 0;
        for (int p = 0; p < 4; p++) wl[p] = 0;
        ev0 = '0;
        ev1 = '0;
    endtask

    task automatic check_all();
        chk("vect_eq", vect0, ev0);
        chk("vect_gt", vect1, ev1);
        chk("ready_eq", {60'd0, ready0}, {60'd0, m_ready()});
        chk("ready_gt", {60'd0, ready1}, {60'd0, m_ready()});
        chk("valid_eq", {32'd0, valid0}, {32'd0, m_valid()});
        chk("valid_gt", {32'd0, valid1}, {32'd0, m_valid()});
    endtask

    // One clock: predict from pre-edge model state and current inputs, then compare.
    task automatic cycle();
        logic [3:0]  rdy;
        logic [31:0] key;
        bit          wrote;
        rdy = m_ready();
        ev0 = '0;
        ev1 = '0;
        for (int r = 0; r < 2; r++) begin
            key = tag_i[r*32 +: 32];
            for (int e = 0; e < 32; e++)
                if (tagValid_i[r] && mv[e] && rdy[e/8]) begin
                    ev0[r*32+e] = (mt[e] == key);
                    ev1[r*32+e] = (mt[e] > key);
                end
        end
        for (int e = 0; e < 32; e++) begin
            if (flush_i) mv[e] = 0;
            else if (wl[e/8] != -1 && !partActive_i[e/8]) mv[e] = 0;
            else begin
                wrote = 0;
                for (int w = 0; w < 2; w++)
                    if (we_i[w] && rdy[e/8] && int'(wrAddr_i[w*5 +: 5]) == e) begin
                        wrote = 1;
                        mt[e] = wrData_i[w*32 +: 32];
                    end
                if (wrote) mv[e] = 1;
                else if (inv_i && int'(invAddr_i) == e) mv[e] = 0;
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (!partActive_i[p]) wl[p] = -1;
            else if (wl[p] == -1) wl[p] = WAKE;
            else if (wl[p] > 0) wl[p] = wl[p] - 1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        we_i = '0; inv_i = 0; flush_i = 0; tagValid_i = '0;
    endtask

    task automatic wr(input int port, input int addr, input logic [31:0] data);
        we_i[port] = 1;
        wrAddr_i[port*5 +: 5] = 5'(addr);
        wrData_i[port*32 +: 32] = data;
    endtask

    task automatic srch(input int port, input logic [31:0] key);
        tagValid_i[port] = 1;
        tag_i[port*32 +: 32] = key;
    endtask

    // Reset asserted away from any clock edge; outputs must clear immediately.
    task automatic async_reset();
        #2 reset = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 0;

        // 1: write then search
        idle(); wr(0, 5, 32'h1000); cycle();
        idle(); srch(0, 32'h1000); cycle();
        chk("t1_hit", vect0[31:0], 64'h20);

        // 2: same-entry write on both ports
        idle(); wr(0, 9, 32'h11); wr(1, 9, 32'h22); cycle();
        idle(); srch(0, 32'h22); srch(1, 32'h11); cycle();
        chk("t2_p1wins", {63'd0, vect0[9]}, 64'd1);
        chk("t2_p0lost", {63'd0, vect0[32+9]}, 64'd0);

        // 3: partition 1 power-down and wake
        for (int e = 8; e < 16; e += 2) begin
            idle(); wr(0, e, 32'h100 + e); wr(1, e + 1, 32'h101 + e); cycle();
        end
        chk("t3_filled", {56'd0, valid0[15:8]}, 64'hFF);
        idle(); partActive_i = 4'b1101; cycle();
        chk("t3_off_ready", {60'd0, ready0}, 64'hD);
        chk("t3_off_valid", {56'd0, valid0[15:8]}, 64'h0);
        idle(); srch(0, 32'h108); cycle();
        chk("t3_off_srch", {56'd0, vect0[15:8]}, 64'h0);
        idle(); partActive_i = 4'b1111; cycle();
        for (int i = 1; i <= WAKE; i++) begin
            idle();
            if (i == 1) wr(0, 10, 32'hABC);
            cycle();
            chk("t3_wake", {63'd0, ready0[1]}, {63'd0, i == WAKE});
        end
        chk("t3_drop", {63'd0, valid0[10]}, 64'd0);

        // 4: greater-than compare
        idle(); wr(0, 0, 32'd5); wr(1, 1, 32'd10); cycle();
        idle(); wr(0, 2, 32'd15); cycle();
        idle(); srch(0, 32'd9); cycle();
        chk("t4_gt", {61'd0, vect1[2:0]}, 64'h6);

        // 5: write vs invalidate, flush vs write
        idle(); wr(0, 3, 32'h33); inv_i = 1; invAddr_i = 5'd3; cycle();
        chk("t5_wr_over_inv", {63'd0, valid0[3]}, 64'd1);
        idle(); wr(0, 4, 32'h44); flush_i = 1; cycle();
        chk("t5_flush", {32'd0, valid0}, 64'd0);

        // 6: same-cycle write/search, then reset during wake
        idle(); wr(0, 7, 32'h77); srch(0, 32'h77); cycle();
        chk("t6_same_cyc", {63'd0, vect0[7]}, 64'd0);
        idle(); srch(0, 32'h77); cycle();
        chk("t6_next_cyc", {63'd0, vect0[7]}, 64'd1);
        idle(); partActive_i = 4'b1011; cycle();
        idle(); partActive_i = 4'b1111; cycle();
        idle(); cycle();
        async_reset();
        chk("t6_rst_ready", {60'd0, ready0}, 64'hF);
        chk("t6_rst_vect", vect0, 64'd0);

        // Randomized traffic over a small tag alphabet so hits are common.
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 39) == 0) partActive_i[$urandom_range(0, 3)] ^= 1'b1;
            for (int w = 0; w < 2; w++)
                if ($urandom_range(0, 1) == 1) wr(w, $urandom_range(0, 31), 32'($urandom_range(0, 7)));
            for (int r = 0; r < 2; r++)
                if ($urandom_range(0, 3) != 0) srch(r, 32'($urandom_range(0, 7)));
            inv_i = ($urandom_range(0, 3) == 0);
            invAddr_i = 5'($urandom_range(0, 31));
            flush_i = ($urandom_range(0, 59) == 0);
            cycle();
            if (n == 300) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
